// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the 2-D data memory: splits the word index into
// X/Y halves, does read-modify-write for sub-doubleword stores and extends load data.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_BITS+2:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    mem_we,
    output logic [ADDR_BITS/2-1:0]  mem_x_addr,
    output logic [ADDR_BITS/2-1:0]  mem_y_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned XY_BITS = ADDR_BITS / 2;
    localparam int unsigned AW      = ADDR_BITS + 3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_DBL  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    misaligned_c;
    logic [5:0]              lane_shift_c;
    logic [DATA_WIDTH-1:0]   rd_shifted_c;
    logic [DATA_WIDTH-1:0]   load_ext_c;
    logic [DATA_WIDTH-1:0]   lane_mask_c;
    logic [DATA_WIDTH-1:0]   merge_mask_c;
    logic [DATA_WIDTH-1:0]   merge_data_c;
    logic                    sign_c;

    // Alignment of the incoming request
    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            SZ_HALF: misaligned_c = req_addr[0];
            SZ_WORD: misaligned_c = |req_addr[1:0];
            SZ_DBL:  misaligned_c = |req_addr[2:0];
            default: misaligned_c = 1'b0;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write
    always_comb begin
        lane_shift_c = {addr_q[2:0], 3'b000};
        rd_shifted_c = mem_rdata >> lane_shift_c;
        sign_c       = 1'b0;
        load_ext_c   = rd_shifted_c;
        lane_mask_c  = '1;
        case (size_q)
            SZ_BYTE: begin
                sign_c      = ~uns_q & rd_shifted_c[7];
                load_ext_c  = {{(DATA_WIDTH-8){sign_c}}, rd_shifted_c[7:0]};
                lane_mask_c = DATA_WIDTH'(8'hFF);
            end
            SZ_HALF: begin
                sign_c      = ~uns_q & rd_shifted_c[15];
                load_ext_c  = {{(DATA_WIDTH-16){sign_c}}, rd_shifted_c[15:0]};
                lane_mask_c = DATA_WIDTH'(16'hFFFF);
            end
            SZ_WORD: begin
                sign_c      = ~uns_q & rd_shifted_c[31];
                load_ext_c  = {{(DATA_WIDTH-32){sign_c}}, rd_shifted_c[31:0]};
                lane_mask_c = DATA_WIDTH'(32'hFFFF_FFFF);
            end
            default: begin
                sign_c      = 1'b0;
                load_ext_c  = rd_shifted_c;
                lane_mask_c = '1;
            end
        endcase
        merge_mask_c = lane_mask_c << lane_shift_c;
        merge_data_c = (mem_rdata & ~merge_mask_c)
                     | (((wdata_q & lane_mask_c) << lane_shift_c) & merge_mask_c);
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    err_d   = misaligned_c;
                    if (misaligned_c) begin
                        state_d = S_RESP;
                    end else if (req_we && (req_size == SZ_DBL)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = we_q ? S_MERGE : S_LOAD;
            S_LOAD: begin
                rdata_d = load_ext_c;
                state_d = S_RESP;
            end
            S_MERGE: state_d = S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    assign mem_x_addr = addr_q[ADDR_BITS+2 -: XY_BITS];
    assign mem_y_addr = addr_q[XY_BITS+2 -: XY_BITS];

    // A write in flight is squashed while Reset is asserted
    assign mem_we    = ((state_q == S_MERGE) || (state_q == S_WRITE)) && !Reset;
    assign mem_wdata = !mem_we               ? '0
                     : (state_q == S_MERGE)  ? merge_data_c
                     :                         wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 64K x 64-bit registered-read memory model.
module tb_lsu_mem_ctrl;

    logic        Clock;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [18:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic        mem_we;
    logic [7:0]  mem_x_addr;
    logic [7:0]  mem_y_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    bit   [63:0] mem [0:65535];

    int          n_checks;
    int          n_fail;
    int          lat;
    int          we_cnt;
    logic        err;
    logic [7:0]  wx;
    logic [7:0]  wy;

    lsu_mem_ctrl #(.ADDR_BITS(16), .DATA_WIDTH(64)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_we       (mem_we),
        .mem_x_addr   (mem_x_addr),
        .mem_y_addr   (mem_y_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory with one-cycle registered read
    always @(posedge Clock) begin
        if (mem_we) mem[{mem_x_addr, mem_y_addr}] <= mem_wdata;
        mem_rdata <= mem[{mem_x_addr, mem_y_addr}];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(input string tag, output int o_lat, output int o_we,
                             output logic o_err, output logic [7:0] o_x, output logic [7:0] o_y);
        int bad;
        o_lat = -1; o_we = 0; o_err = 1'b0; o_x = '0; o_y = '0; bad = 0;
        for (int c = 1; c <= 8 && o_lat < 0; c++) begin
            @(negedge Clock);
            if (mem_we) begin
                o_we++;
                o_x = mem_x_addr;
                o_y = mem_y_addr;
            end else if (mem_wdata != 64'd0) begin
                bad++;
            end
            if (resp_valid) begin
                o_lat = c;
                o_err = resp_err;
            end
        end
        chk({tag, "_wdata_idle"}, 64'(bad), 64'd0);
        if (o_lat > 0) begin
            @(negedge Clock);
            chk({tag, "_pulse"}, 64'(resp_valid), 64'd0);
            chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [18:0] addr, input logic [63:0] wdata);
        @(negedge Clock);
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge Clock);
        #1 req_valid = 1'b0;
        wait_resp(tag, lat, we_cnt, err, wx, wy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);

        run_req("st_d", 1'b1, 2'd3, 1'b0, 19'h00010, 64'h0123_4567_89AB_CDEF);
        chk("st_d_lat", 64'(lat), 64'd2);
        chk("st_d_wecnt", 64'(we_cnt), 64'd1);
        chk("st_d_x", 64'(wx), 64'h00);
        chk("st_d_y", 64'(wy), 64'h02);
        chk("st_d_mem", mem[16'h0002], 64'h0123_4567_89AB_CDEF);

        run_req("ld_d", 1'b0, 2'd3, 1'b0, 19'h00010, 64'd0);
        chk("ld_d_lat", 64'(lat), 64'd3);
        chk("ld_d_wecnt", 64'(we_cnt), 64'd0);
        chk("ld_d_data", resp_rdata, 64'h0123_4567_89AB_CDEF);

        run_req("st_b", 1'b1, 2'd0, 1'b0, 19'h00013, 64'h0000_0000_0000_0080);
        chk("st_b_lat", 64'(lat), 64'd3);
        chk("st_b_wecnt", 64'(we_cnt), 64'd1);
        chk("st_b_mem", mem[16'h0002], 64'h0123_4567_80AB_CDEF);
        chk("st_b_rdata_kept", resp_rdata, 64'h0123_4567_89AB_CDEF);

        run_req("ld_bs", 1'b0, 2'd0, 1'b0, 19'h00013, 64'd0);
        chk("ld_bs_data", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_req("ld_bu", 1'b0, 2'd0, 1'b1, 19'h00013, 64'd0);
        chk("ld_bu_data", resp_rdata, 64'h0000_0000_0000_0080);

        run_req("st_h", 1'b1, 2'd1, 1'b0, 19'h00016, 64'h0000_0000_0000_BEEF);
        chk("st_h_mem", mem[16'h0002], 64'hBEEF_4567_80AB_CDEF);
        run_req("ld_ws", 1'b0, 2'd2, 1'b0, 19'h00014, 64'd0);
        chk("ld_ws_lat", 64'(lat), 64'd3);
        chk("ld_ws_data", resp_rdata, 64'hFFFF_FFFF_BEEF_4567);
        run_req("ld_hu", 1'b0, 2'd1, 1'b1, 19'h00016, 64'd0);
        chk("ld_hu_data", resp_rdata, 64'h0000_0000_0000_BEEF);

        run_req("mis", 1'b0, 2'd1, 1'b0, 19'h00001, 64'd0);
        chk("mis_lat", 64'(lat), 64'd1);
        chk("mis_err", 64'(err), 64'd1);
        chk("mis_wecnt", 64'(we_cnt), 64'd0);
        chk("mis_rdata_kept", resp_rdata, 64'h0000_0000_0000_BEEF);
        run_req("mis_st", 1'b1, 2'd3, 1'b0, 19'h00014, 64'hDEAD_DEAD_DEAD_DEAD);
        chk("mis_st_err", 64'(err), 64'd1);
        chk("mis_st_wecnt", 64'(we_cnt), 64'd0);
        chk("mis_st_mem", mem[16'h0002], 64'hBEEF_4567_80AB_CDEF);

        // Top address store with req_valid held high into a following load
        @(negedge Clock);
        req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 19'h7FFF8; req_wdata = 64'hA5A5_0F0F_1234_5678;
        req_valid = 1'b1;
        @(posedge Clock);
        #1 req_we = 1'b0; req_wdata = 64'd0;
        @(negedge Clock);
        chk("top_c1_ready", 64'(req_ready), 64'd0);
        chk("top_c1_we", 64'(mem_we), 64'd1);
        chk("top_c1_x", 64'(mem_x_addr), 64'hFF);
        chk("top_c1_y", 64'(mem_y_addr), 64'hFF);
        @(negedge Clock);
        chk("top_c2_ready", 64'(req_ready), 64'd0);
        chk("top_c2_resp", 64'(resp_valid), 64'd1);
        @(negedge Clock);
        chk("top_c3_ready", 64'(req_ready), 64'd1);
        chk("top_c3_resp", 64'(resp_valid), 64'd0);
        chk("top_mem", mem[16'hFFFF], 64'hA5A5_0F0F_1234_5678);
        @(posedge Clock);
        #1 req_valid = 1'b0;
        wait_resp("top_ld", lat, we_cnt, err, wx, wy);
        chk("top_ld_lat", 64'(lat), 64'd3);
        chk("top_ld_data", resp_rdata, 64'hA5A5_0F0F_1234_5678);

        // Reset during the MERGE cycle of a byte store
        @(negedge Clock);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 19'h00010; req_wdata = 64'h55;
        req_valid = 1'b1;
        @(posedge Clock);
        #1 req_valid = 1'b0;
        @(negedge Clock);
        chk("rm_read_we", 64'(mem_we), 64'd0);
        @(negedge Clock);
        chk("rm_merge_we", 64'(mem_we), 64'd1);
        Reset = 1'b1;
        #1;
        chk("rm_rst_we", 64'(mem_we), 64'd0);
        chk("rm_rst_wdata", mem_wdata, 64'd0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        chk("rm_idle_ready", 64'(req_ready), 64'd1);
        chk("rm_no_resp", 64'(resp_valid), 64'd0);
        chk("rm_rdata_clr", resp_rdata, 64'd0);
        @(negedge Clock);
        chk("rm_no_resp2", 64'(resp_valid), 64'd0);
        chk("rm_mem", mem[16'h0002], 64'hBEEF_4567_80AB_CDEF);
        run_req("rm_ld", 1'b0, 2'd3, 1'b0, 19'h00010, 64'd0);
        chk("rm_ld_data", resp_rdata, 64'hBEEF_4567_80AB_CDEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller that sits directly upstream of the 2-D data memory (64-bit word, split row/column address, 1-cycle registered read). It accepts byte-addressed load/store requests from the execute/memory pipeline stage and splits the word index into X (row) and Y (column) halves. It performs read-modify-write for sub-doubleword stores and returns size-extracted, sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
ADDR_BITS, 16, word-index width; X and Y addresses are ADDR_BITS/2 each
DATA_WIDTH, 64, memory word width; byte-lane logic is fixed for 64 (8 lanes)

Ports:
Clock  input  1  single clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  input  1  zero-extend load (ignored for double and for stores)
req_addr  input  ADDR_BITS+3  byte address; [2:0] = byte offset, [ADDR_BITS+2:3] = word index
req_wdata  input  DATA_WIDTH  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid; 1 = misaligned, no memory access
resp_rdata  output  DATA_WIDTH  load result; held until next load completes
mem_we  output  1  to memory WriteEnable
mem_x_addr  output  ADDR_BITS/2  word index upper half
mem_y_addr  output  ADDR_BITS/2  word index lower half
mem_wdata  output  DATA_WIDTH  to memory Data_in
mem_rdata  input  DATA_WIDTH  from memory Data_out (valid the cycle after the address is presented)

Behaviour:
- Reset: state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, latched request fields = 0, mem_we = 0.
- Handshake: accept on posedge with req_valid && req_ready. req_valid is ignored while busy. No response backpressure.
- Latches addr, we, size, unsigned, and wdata at accept. mem_x_addr/mem_y_addr are always driven from the latched word index: X = index[ADDR_BITS-1:ADDR_BITS/2], Y = index[ADDR_BITS/2-1:0].
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. Byte is always aligned.
- States:
  - IDLE: if a request is accepted:
    - misaligned -> RESP with error
    - else store double -> WRITE
    - else -> READ
  - READ: mem_we = 0, address presented. Next: load -> LOAD; store -> MERGE.
  - LOAD: mem_rdata is valid. Extract lane(s) at byte offset o (little-endian, byte o = bits 8o+7:8o). Sign-extend, or zero-extend if unsigned. Register into resp_rdata. -> RESP.
  - MERGE: mem_we = 1. mem_wdata = mem_rdata with the addressed byte lanes replaced by the low 8/16/32 bits of wdata. -> RESP.
  - WRITE: mem_we = 1, mem_wdata = wdata. -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle; resp_err = 1 only on the misaligned path. -> IDLE.
- Latency, accept edge to resp_valid cycle: load 3 cycles; sub-double store 3; double store 2; misaligned 1. Throughput is one request per latency+1 cycles.
- mem_we = (state is MERGE or WRITE) && !Reset. A write pending in the cycle Reset is high is suppressed.
- mem_wdata = 0 when mem_we = 0.
- Misaligned requests never assert mem_we and leave resp_rdata unchanged.
- Stores leave resp_rdata unchanged.
- Reset mid-operation: aborts to IDLE; no resp_valid is issued for the aborted request.
- Word-index wrap: none; every index is in range by construction.

Test Plan:
- Store double 0x0123_4567_89AB_CDEF at addr 0x0010, then load double at 0x0010 -> mem_we high for exactly 1 cycle with X=0x00, Y=0x02; resp_rdata = 0x0123456789ABCDEF; resp_valid 3 cycles after the load accept.
- Store byte 0x80 at addr 0x0013 over that word, then load signed byte 0x0013 -> word becomes 0x0123456780ABCDEF; resp_rdata = 0xFFFF_FFFF_FFFF_FF80. Unsigned reload -> 0x0000_0000_0000_0080.
- Store half 0xBEEF at 0x0016, then load signed word at 0x0014 -> resp_rdata = 0xFFFF_FFFF_BEEF_4567.
- Load half at 0x0001 -> resp_valid with resp_err=1 one cycle after accept; mem_we never asserted; resp_rdata unchanged.
- Top address: store double at 0x7FFF8 -> X=0xFF, Y=0xFF. Hold req_valid high during busy -> req_ready=0 and the second request is accepted only after returning to IDLE.
- Assert Reset during the MERGE cycle -> mem_we=0 that cycle; memory word unchanged on reload; no resp_valid; state IDLE next cycle.
